digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 32, total operand width in bits.
REQ-002 Parameter DIGIT, default 8, bits added per clock; WIDTH SHALL be an integer multiple of DIGIT, and DIGIT >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for the add operation.
REQ-010 sub  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+1; cin ignored).
REQ-011 out_valid  output  1  result presented.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (in subtract: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The block SHALL contain a three-state FSM: IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Accept: in IDLE, when in_valid && in_ready is sampled at an edge, the block SHALL capture a, b (inverted when sub=1), the effective carry-in (cin, or 1 when sub=1), go to RUN, and clear the digit counter to 0.
REQ-019 In RUN, each cycle SHALL add digit k (bits k*DIGIT+DIGIT-1..k*DIGIT) of the captured operands plus the carry register, write that digit of sum, update the carry register, and increment k.
REQ-020 After digit N-1 is processed, the FSM SHALL enter DONE; out_valid SHALL first be high N+1 cycles after the accept edge, which is a latency of N+1.
REQ-021 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, computed on the final digit.
REQ-022 sum, cout and ovf SHALL remain stable while out_valid=1 && out_ready=0.
REQ-023 In DONE, when out_ready=1 the FSM SHALL return to IDLE on that edge; no new operand is accepted on the same edge.
REQ-024 Inputs a, b, cin and sub SHALL be ignored outside the accept edge, so changes during RUN or DONE have no effect.
REQ-025 in_valid while not in IDLE SHALL be held off by in_ready=0 and SHALL neither be lost nor queued by this block.
REQ-026 Boundary DIGIT=WIDTH: RUN SHALL last exactly one cycle, giving a latency of 2.
REQ-027 The carry chain SHALL propagate across digit boundaries with no lost carry, including a full ripple from bit 0 to WIDTH-1.
REQ-028 Minimum issue interval SHALL be N+2 cycles with out_ready held at 1.

Reset
REQ-029 While rst_n=0, the block SHALL force the FSM to IDLE, the digit counter to 0, the carry register to 0, sum to 0, cout to 0, ovf to 0 and out_valid to 0. in_ready SHALL be 1 once reset is released.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately (asynchronously), and no partial result SHALL be presented.
REQ-031 The first accept after reset deassertion SHALL be possible at the first rising edge at which rst_n=1.

Verification (WIDTH=32, DIGIT=8, N=4 unless stated)
REQ-032 Add a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid high exactly 5 cycles after the accept edge.
REQ-033 Subtract a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> sum=0x00000002, cout=1.
REQ-034 Signed overflow a=0x7FFFFFFF, b=1, cin=0, sub=0 -> sum=0x80000000, ovf=1, cout=0; sub=1 with a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling a and b -> outputs stable and in_ready=0 throughout; raise out_ready -> in_ready=1 on the next cycle.
REQ-036 Reset mid-RUN after 2 digits are processed -> out_valid never asserts, sum=0, in_ready=1 after release; the next add 3+4 returns 7.
REQ-037 Randomised sweep for the parameter pairs (32,8), (32,32), (12,4) and (8,1), with at least 1000 operations per pair, against an arithmetic model with random in_valid and out_ready -> all results match, and each observed latency equals N+1.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock over WIDTH/DIGIT cycles,
// with valid/ready handshakes on the operand side and on the result side.
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dig_sum;
    logic             carry_into_msb;
    logic             last_digit;
    logic [WIDTH-1:0] acc_next;

    // Operands shift right one digit per cycle, so the active digit is always the low slice;
    // the sum digits shift in from the top and land in place after the final digit.
    always_comb begin
        dig_a          = op_a[DIGIT-1:0];
        dig_b          = op_b[DIGIT-1:0];
        dig_sum        = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry};
        carry_into_msb = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_sum[DIGIT-1];
        last_digit     = (k == KW'(N - 1));
        acc_next       = (acc >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= sub ? ~b : b;
                        carry    <= sub | cin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= dig_sum[DIGIT];
                    acc   <= acc_next;
                    k     <= k + 1'b1;
                    // Result registers load only on the final digit, so a partial sum is never visible.
                    if (last_digit) begin
                        sum       <= acc_next;
                        cout      <= dig_sum[DIGIT];
                        ovf       <= carry_into_msb ^ dig_sum[DIGIT];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed checks of digit_serial_adder (32/8), plus a random sweep over
// four WIDTH/DIGIT pairs checked against an arithmetic model.
`timescale 1ns/1ps
module tb_digit_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    int checks   = 0;
    int failures = 0;

    digit_serial_adder #(.WIDTH(32), .DIGIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Sweep instances: 0=(32,8) 1=(32,32) 2=(12,4) 3=(8,1)
    logic [3:0]  r_in_valid, r_cin, r_sub, r_out_ready;
    wire  [3:0]  r_in_ready, r_out_valid, r_cout, r_ovf;
    logic [31:0] r_a [4];
    logic [31:0] r_b [4];
    wire  [31:0] r_sum0, r_sum1;
    wire  [11:0] r_sum2;
    wire  [7:0]  r_sum3;

    digit_serial_adder #(.WIDTH(32), .DIGIT(8)) sw0 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]),
        .a(r_a[0]), .b(r_b[0]), .cin(r_cin[0]), .sub(r_sub[0]), .out_valid(r_out_valid[0]),
        .out_ready(r_out_ready[0]), .sum(r_sum0), .cout(r_cout[0]), .ovf(r_ovf[0])
    );
    digit_serial_adder #(.WIDTH(32), .DIGIT(32)) sw1 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]),
        .a(r_a[1]), .b(r_b[1]), .cin(r_cin[1]), .sub(r_sub[1]), .out_valid(r_out_valid[1]),
        .out_ready(r_out_ready[1]), .sum(r_sum1), .cout(r_cout[1]), .ovf(r_ovf[1])
    );
    digit_serial_adder #(.WIDTH(12), .DIGIT(4)) sw2 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[2]), .in_ready(r_in_ready[2]),
        .a(r_a[2][11:0]), .b(r_b[2][11:0]), .cin(r_cin[2]), .sub(r_sub[2]), .out_valid(r_out_valid[2]),
        .out_ready(r_out_ready[2]), .sum(r_sum2), .cout(r_cout[2]), .ovf(r_ovf[2])
    );
    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) sw3 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[3]), .in_ready(r_in_ready[3]),
        .a(r_a[3][7:0]), .b(r_b[3][7:0]), .cin(r_cin[3]), .sub(r_sub[3]), .out_valid(r_out_valid[3]),
        .out_ready(r_out_ready[3]), .sum(r_sum3), .cout(r_cout[3]), .ovf(r_ovf[3])
    );

    function automatic logic [31:0] sweep_sum(input int i);
        case (i)
            0:       return r_sum0;
            1:       return r_sum1;
            2:       return {20'd0, r_sum2};
            default: return {24'd0, r_sum3};
        endcase
    endfunction

    // Presents one operand set at a negedge and waits for the result; lat counts the
    // accept cycle as cycle 1, so the first visible result lands at N+1.
    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                         input logic vsub, input bit release_rst,
                         output logic [31:0] res, output logic rc, output logic ro, output int lat);
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b0;
        lat = 0; res = '0; rc = 1'b0; ro = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c; res = sum; rc = cout; ro = ovf;
                break;
            end
        end
        checks++;
        if (lat == 0) begin
            failures++;
            $display("[TB] FAIL op_timeout: got no out_valid within 40 cycles, required one");
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] s; logic c, o; int lat;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (sum !== 32'h0) begin failures++; $display("[TB] FAIL rst_sum: got %h required 00000000", sum); end
        checks++; if ({cout, ovf} !== 2'b00) begin failures++; $display("[TB] FAIL rst_flags: got %b required 00", {cout, ovf}); end
        // Operands offered in the same cycle reset releases must be accepted at the first edge.
        do_op(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, s, c, o, lat);
        checks++; if (s !== 32'd3) begin failures++; $display("[TB] FAIL first_after_reset_sum: got %h required 00000003", s); end
        checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL first_after_reset_lat: got %0d required 5", lat); end
    endtask

    task automatic test_add();
        logic [31:0] s; logic c, o; int lat;
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'h0, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL ripple_add: got sum=%h cout=%b ovf=%b required sum=00000000 cout=1 ovf=0", s, c, o); end
        checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL ripple_lat: got %0d required 5", lat); end
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'h23456789, 1'b0, 1'b0}) begin failures++; $display("[TB] FAIL plain_add: got sum=%h cout=%b ovf=%b required sum=23456789 cout=0 ovf=0", s, c, o); end
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'hFFFFFFFF, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL ones_add: got sum=%h cout=%b ovf=%b required sum=ffffffff cout=1 ovf=0", s, c, o); end
    endtask

    task automatic test_subtract();
        logic [31:0] s; logic c, o; int lat;
        do_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin failures++; $display("[TB] FAIL sub_5_7: got sum=%h cout=%b ovf=%b required sum=fffffffe cout=0 ovf=0", s, c, o); end
        do_op(32'd7, 32'd5, 1'b1, 1'b1, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'h2, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL sub_7_5: got sum=%h cout=%b ovf=%b required sum=00000002 cout=1 ovf=0", s, c, o); end
    endtask

    task automatic test_overflow();
        logic [31:0] s; logic c, o; int lat;
        do_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'h80000000, 1'b0, 1'b1}) begin failures++; $display("[TB] FAIL ovf_add: got sum=%h cout=%b ovf=%b required sum=80000000 cout=0 ovf=1", s, c, o); end
        do_op(32'h80000000, 32'd1, 1'b0, 1'b1, 1'b0, s, c, o, lat);
        checks++; if ({s, c, o} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin failures++; $display("[TB] FAIL ovf_sub: got sum=%h cout=%b ovf=%b required sum=7fffffff cout=1 ovf=1", s, c, o); end
    endtask

    task automatic test_backpressure();
        bit got; int lat;
        @(negedge clk);
        a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin got = 1; break; end
        end
        checks++; if (!got) begin failures++; $display("[TB] FAIL bp_wait: got no out_valid, required one"); end
        // Stall with in_valid raised and operand inputs churning; nothing may move.
        for (int c = 0; c < 10; c++) begin
            a = ~a; b = b + 32'h11; sub = ~sub; cin = ~cin; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({sum, cout, ovf, out_valid} !== {32'h10101010, 1'b0, 1'b0, 1'b1}) begin
                failures++;
                $display("[TB] FAIL bp_stable: got sum=%h cout=%b ovf=%b out_valid=%b required 10101010/0/0/1", sum, cout, ovf, out_valid);
            end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready: got %b required 0", in_ready); end
        end
        a = 32'd100; b = 32'd23; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("[TB] FAIL bp_release: got in_ready/out_valid=%b required 10", {in_ready, out_valid}); end
        // The held-off request is taken now, and input changes after the accept are ignored.
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (c == 1) begin a = 32'hDEADBEEF; b = 32'h12345678; sub = 1'b1; end
            if (out_valid) begin lat = c; break; end
        end
        checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL held_req_lat: got %0d required 5", lat); end
        checks++; if (sum !== 32'd123) begin failures++; $display("[TB] FAIL held_req_sum: got %h required 0000007b", sum); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s; logic c, o; int lat; bit seen;
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, sum} !== {1'b0, 32'h0}) begin failures++; $display("[TB] FAIL midrun_reset: got out_valid=%b sum=%h required 0/00000000", out_valid, sum); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrun_in_ready: got %b required 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || sum !== 32'h0) seen = 1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL midrun_no_result: got a partial result, required none"); end
        do_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, s, c, o, lat);
        checks++; if (s !== 32'd7) begin failures++; $display("[TB] FAIL midrun_next_add: got %h required 00000007", s); end
    endtask

    task automatic test_back_to_back();
        int first_res, issue2, lat2; logic [31:0] s1, s2;
        @(negedge clk);
        a = 32'd10; b = 32'd20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        first_res = 0; issue2 = 0; s1 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin a = 32'd1000; b = 32'd234; end
            if (out_valid && first_res == 0) begin first_res = c; s1 = sum; end
            if (in_ready) begin issue2 = c; break; end
        end
        checks++; if (first_res !== 5) begin failures++; $display("[TB] FAIL b2b_lat1: got %0d required 5", first_res); end
        checks++; if (s1 !== 32'd30) begin failures++; $display("[TB] FAIL b2b_sum1: got %h required 0000001e", s1); end
        checks++; if (issue2 !== 6) begin failures++; $display("[TB] FAIL b2b_interval: got %0d required 6", issue2); end
        lat2 = 0; s2 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin lat2 = c; s2 = sum; break; end
        end
        checks++; if (lat2 !== 5) begin failures++; $display("[TB] FAIL b2b_lat2: got %0d required 5", lat2); end
        checks++; if (s2 !== 32'd1234) begin failures++; $display("[TB] FAIL b2b_sum2: got %h required 000004d2", s2); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random_sweep();
        int wid [4] = '{32, 32, 12, 8};
        int nd  [4] = '{4, 1, 3, 8};
        int issued [4]; int consumed [4]; int acc_cyc [4]; bit seen [4];
        logic [31:0] e_sum [4]; logic e_cout [4]; logic e_ovf [4];
        logic [31:0] mask, am, bm, got_sum; logic [32:0] full;
        int cyc; bit busy_any;
        for (int i = 0; i < 4; i++) begin
            issued[i] = 0; consumed[i] = 0; acc_cyc[i] = 0; seen[i] = 0;
            e_sum[i] = '0; e_cout[i] = 1'b0; e_ovf[i] = 1'b0;
        end
        cyc = 0;
        busy_any = 1;
        while (busy_any && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            busy_any = 0;
            for (int i = 0; i < 4; i++) begin
                r_in_valid[i]  = (issued[i] < 1000) && ($urandom_range(0, 3) != 0);
                r_a[i]         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
                r_b[i]         = ($urandom_range(0, 7) == 0) ? 32'h00000000 : $urandom();
                r_cin[i]       = $urandom_range(0, 1) == 1;
                r_sub[i]       = $urandom_range(0, 1) == 1;
                r_out_ready[i] = $urandom_range(0, 1) == 1;
                if (r_out_valid[i]) begin
                    if (!seen[i]) begin
                        seen[i] = 1;
                        checks++;
                        if (cyc - acc_cyc[i] != nd[i] + 1) begin
                            failures++;
                            $display("[TB] FAIL sweep%0d_lat: got %0d required %0d", i, cyc - acc_cyc[i], nd[i] + 1);
                        end
                    end
                    if (r_out_ready[i]) begin
                        got_sum = sweep_sum(i);
                        checks++;
                        if ({got_sum, r_cout[i], r_ovf[i]} !== {e_sum[i], e_cout[i], e_ovf[i]}) begin
                            failures++;
                            $display("[TB] FAIL sweep%0d_result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                                     i, got_sum, r_cout[i], r_ovf[i], e_sum[i], e_cout[i], e_ovf[i]);
                        end
                        consumed[i]++;
                        seen[i] = 0;
                    end
                end
                if (r_in_valid[i] && r_in_ready[i]) begin
                    mask = (wid[i] == 32) ? 32'hFFFFFFFF : ((32'd1 << wid[i]) - 32'd1);
                    am   = r_a[i] & mask;
                    bm   = (r_sub[i] ? ~r_b[i] : r_b[i]) & mask;
                    full = {1'b0, am} + {1'b0, bm} + {32'd0, (r_sub[i] | r_cin[i])};
                    e_sum[i]  = full[31:0] & mask;
                    e_cout[i] = full[wid[i]];
                    e_ovf[i]  = (am[wid[i]-1] == bm[wid[i]-1]) && (full[wid[i]-1] != am[wid[i]-1]);
                    acc_cyc[i] = cyc;
                    issued[i]++;
                end
                if (consumed[i] < 1000) busy_any = 1;
            end
        end
        r_in_valid = '0;
        r_out_ready = '0;
        checks++;
        if (busy_any) begin
            failures++;
            $display("[TB] FAIL sweep_timeout: got %0d/%0d/%0d/%0d results required 1000 each",
                     consumed[0], consumed[1], consumed[2], consumed[3]);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        r_in_valid = '0; r_cin = '0; r_sub = '0; r_out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            r_a[i] = '0;
            r_b[i] = '0;
        end
        test_reset();
        test_add();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
